// File: rtl/bcd_operand_entry_pkg.sv
// rtl/bcd_operand_entry_pkg.sv - key codes, state encoding and defaults for bcd_operand_entry
package bcd_operand_entry_pkg;

  localparam int NDIGITS_DEF = 3;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_PLUS      = 4'd10;
  localparam logic [3:0] KEY_MINUS     = 4'd11;
  localparam logic [3:0] KEY_EQ        = 4'd12;
  localparam logic [3:0] KEY_NEG       = 4'd13;
  localparam logic [3:0] KEY_BKSP      = 4'd14;
  localparam logic [3:0] KEY_CLEAR     = 4'd15;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_operand_entry_digit_shreg.sv
// rtl/bcd_operand_entry_digit_shreg.sv - per-operand BCD digit shift register with digit counter
module bcd_digit_shreg #(
  parameter int NDIGITS = 3,
  parameter int CW      = $clog2(NDIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr,
  input  logic                 load,
  input  logic [3:0]           din,
  input  logic [4*NDIGITS-1:0] load_val,
  output logic [4*NDIGITS-1:0] val,
  output logic [CW-1:0]        cnt
);

  localparam int W = 4 * NDIGITS;

  // clr together with push restarts the operand with din as its only digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= '0;
      cnt <= '0;
    end else if (load) begin
      val <= load_val;
      cnt <= CW'(NDIGITS);
    end else if (clr) begin
      val <= push ? {{(W-4){1'b0}}, din} : '0;
      cnt <= push ? CW'(1) : '0;
    end else if (push && (cnt < CW'(NDIGITS))) begin
      val <= {val[W-5:0], din};
      cnt <= cnt + 1'b1;
    end else if (pop && (cnt != '0)) begin
      val <= val >> 4;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/bcd_operand_entry.sv
// rtl/bcd_operand_entry.sv - keypad operand entry for the signed BCD add/sub datapath
// Optional result chaining in DONE is enabled by defining CHAIN_RESULT_EN.
module bcd_operand_entry
  import bcd_operand_entry_pkg::*;
#(
  parameter int NDIGITS = NDIGITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  output logic                 key_ready,
  output logic [4*NDIGITS-1:0] a_bcd,
  output logic [4*NDIGITS-1:0] b_bcd,
  output logic                 a_sign,
  output logic                 b_sign,
  output logic                 mode,
  output logic                 issue,
  output logic                 entry_b,
  input  logic [4*NDIGITS-1:0] res_bcd,
  input  logic                 res_sign,
  input  logic                 res_cout
);

  localparam int CW = $clog2(NDIGITS + 1);

  state_t        state, nxt_state;
  logic          acc, digit;
  logic          a_push, a_pop, a_clr, a_load;
  logic          b_push, b_pop, b_clr;
  logic          mode_n, a_sign_n, b_sign_n;
  logic [CW-1:0] a_cnt_unused, b_cnt;

  assign acc   = key_valid && key_ready;
  assign digit = is_digit(key_code);

  always_comb begin
    nxt_state = state;
    a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_load = 1'b0;
    b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0;
    mode_n = mode; a_sign_n = a_sign; b_sign_n = b_sign;
    if (state == ST_ISSUE) begin
      nxt_state = ST_DONE;
    end else if (acc && key_code == KEY_CLEAR) begin
      a_clr = 1'b1; b_clr = 1'b1;
      mode_n = 1'b0; a_sign_n = 1'b0; b_sign_n = 1'b0;
      nxt_state = ST_ENTER_A;
    end else if (acc) begin
      case (state)
        ST_ENTER_A: begin
          if (digit)                       a_push = 1'b1;
          else if (key_code == KEY_BKSP)   a_pop = 1'b1;
          else if (key_code == KEY_NEG)    a_sign_n = ~a_sign;
          else if (key_code == KEY_PLUS || key_code == KEY_MINUS) begin
            mode_n = (key_code == KEY_MINUS);
            b_clr = 1'b1; b_sign_n = 1'b0;
            nxt_state = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (digit)                       b_push = 1'b1;
          else if (key_code == KEY_BKSP)   b_pop = 1'b1;
          else if (key_code == KEY_NEG)    b_sign_n = ~b_sign;
          else if (key_code == KEY_EQ)     nxt_state = ST_ISSUE;
          else if ((key_code == KEY_PLUS || key_code == KEY_MINUS) && b_cnt == '0)
            mode_n = (key_code == KEY_MINUS);
        end
        ST_DONE: begin
          if (digit) begin
            a_clr = 1'b1; a_push = 1'b1; b_clr = 1'b1;
            mode_n = 1'b0; a_sign_n = 1'b0; b_sign_n = 1'b0;
            nxt_state = ST_ENTER_A;
          end else if (key_code == KEY_EQ) begin
            nxt_state = ST_ISSUE;
          end
`ifdef CHAIN_RESULT_EN
          // an overflowed result cannot be represented as A, so the key is dropped
          else if ((key_code == KEY_PLUS || key_code == KEY_MINUS) && !res_cout) begin
            a_load = 1'b1; a_sign_n = res_sign;
            mode_n = (key_code == KEY_MINUS);
            b_clr = 1'b1; b_sign_n = 1'b0;
            nxt_state = ST_ENTER_B;
          end
`endif
        end
        default: nxt_state = state;
      endcase
    end
  end

`ifndef CHAIN_RESULT_EN
  logic unused_res;
  assign unused_res = ^{res_bcd, res_sign, res_cout};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ENTER_A;
      mode      <= 1'b0;
      a_sign    <= 1'b0;
      b_sign    <= 1'b0;
      issue     <= 1'b0;
      key_ready <= 1'b1;
      entry_b   <= 1'b0;
    end else begin
      state     <= nxt_state;
      mode      <= mode_n;
      a_sign    <= a_sign_n;
      b_sign    <= b_sign_n;
      issue     <= (nxt_state == ST_ISSUE);
      key_ready <= (nxt_state != ST_ISSUE);
      entry_b   <= (nxt_state != ST_ENTER_A);
    end
  end

  bcd_digit_shreg #(.NDIGITS(NDIGITS), .CW(CW)) u_a (
    .clk(clk), .rst(rst), .push(a_push), .pop(a_pop), .clr(a_clr), .load(a_load),
    .din(key_code), .load_val(res_bcd), .val(a_bcd), .cnt(a_cnt_unused)
  );

  bcd_digit_shreg #(.NDIGITS(NDIGITS), .CW(CW)) u_b (
    .clk(clk), .rst(rst), .push(b_push), .pop(b_pop), .clr(b_clr), .load(1'b0),
    .din(key_code), .load_val({4*NDIGITS{1'b0}}), .val(b_bcd), .cnt(b_cnt)
  );

endmodule

// File: tb/tb_bcd_operand_entry.sv
// tb/tb_bcd_operand_entry.sv - directed self-checking bench for bcd_operand_entry
module tb_bcd_operand_entry;

  localparam logic [3:0] K_PLUS = 4'd10, K_MINUS = 4'd11, K_EQ = 4'd12;
  localparam logic [3:0] K_NEG = 4'd13, K_BKSP = 4'd14, K_CLR = 4'd15;

  logic        clk = 1'b0;
  logic        rst, key_valid, key_ready;
  logic [3:0]  key_code;
  logic [11:0] a_bcd, b_bcd, res_bcd;
  logic        a_sign, b_sign, mode, issue, entry_b, res_sign, res_cout;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  bcd_operand_entry dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .a_bcd(a_bcd), .b_bcd(b_bcd), .a_sign(a_sign),
    .b_sign(b_sign), .mode(mode), .issue(issue), .entry_b(entry_b),
    .res_bcd(res_bcd), .res_sign(res_sign), .res_cout(res_cout)
  );

  task automatic press(input logic [3:0] k);
    @(negedge clk); key_valid = 1'b1; key_code = k;
    @(negedge clk); key_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (a_bcd !== 12'h000 || b_bcd !== 12'h000) begin errors++; $display("FAIL reset_ops got a=%h b=%h want 000 000", a_bcd, b_bcd); end
    checks++; if ({a_sign, b_sign, mode} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {a_sign, b_sign, mode}); end
    checks++; if ({issue, entry_b, key_ready} !== 3'b001) begin errors++; $display("FAIL reset_ctrl got %b want 001", {issue, entry_b, key_ready}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    press(K_CLR);
    press(4'd1); press(4'd2); press(4'd3); press(K_PLUS);
    checks++; if (entry_b !== 1'b1) begin errors++; $display("FAIL basic_entry_b got %b want 1", entry_b); end
    press(4'd4); press(4'd5); press(K_EQ);
    checks++; if (issue !== 1'b1 || key_ready !== 1'b0) begin errors++; $display("FAIL basic_issue got issue=%b rdy=%b want 1 0", issue, key_ready); end
    checks++; if (a_bcd !== 12'h123 || b_bcd !== 12'h045) begin errors++; $display("FAIL basic_ops got a=%h b=%h want 123 045", a_bcd, b_bcd); end
    checks++; if ({a_sign, b_sign, mode} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b want 000", {a_sign, b_sign, mode}); end
    @(negedge clk);
    checks++; if (issue !== 1'b0 || key_ready !== 1'b1 || entry_b !== 1'b1) begin errors++; $display("FAIL basic_pulse_end got issue=%b rdy=%b eb=%b want 0 1 1", issue, key_ready, entry_b); end
  endtask

  task automatic test_digit_limit;
    press(K_CLR);
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    checks++; if (a_bcd !== 12'h987) begin errors++; $display("FAIL limit_full got %h want 987", a_bcd); end
    press(K_BKSP);
    checks++; if (a_bcd !== 12'h098) begin errors++; $display("FAIL limit_bksp1 got %h want 098", a_bcd); end
    press(K_BKSP); press(K_BKSP);
    checks++; if (a_bcd !== 12'h000) begin errors++; $display("FAIL limit_bksp3 got %h want 000", a_bcd); end
    press(K_BKSP); press(4'd5); press(4'd6);
    checks++; if (a_bcd !== 12'h056) begin errors++; $display("FAIL limit_bksp4 got %h want 056", a_bcd); end
  endtask

  task automatic test_signs;
    press(K_CLR);
    press(4'd5); press(K_NEG); press(K_MINUS); press(4'd7); press(K_NEG); press(K_EQ);
    checks++; if ({a_sign, b_sign, mode} !== 3'b111) begin errors++; $display("FAIL signs_flags got %b want 111", {a_sign, b_sign, mode}); end
    checks++; if (a_bcd !== 12'h005 || b_bcd !== 12'h007) begin errors++; $display("FAIL signs_ops got a=%h b=%h want 005 007", a_bcd, b_bcd); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL signs_issue got %b want 1", issue); end
    @(negedge clk);
    press(K_CLR); press(K_NEG);
    checks++; if (a_sign !== 1'b1 || a_bcd !== 12'h000) begin errors++; $display("FAIL signs_neg_zero got s=%b a=%h want 1 000", a_sign, a_bcd); end
  endtask

  task automatic test_mode_overwrite;
    press(K_CLR);
    press(4'd1); press(K_PLUS); press(K_MINUS);
    checks++; if (mode !== 1'b1) begin errors++; $display("FAIL mode_overwrite got %b want 1", mode); end
    press(4'd2); press(K_PLUS);
    checks++; if (mode !== 1'b1 || b_bcd !== 12'h002) begin errors++; $display("FAIL mode_locked got m=%b b=%h want 1 002", mode, b_bcd); end
    press(K_EQ);
    checks++; if (a_bcd !== 12'h001 || issue !== 1'b1) begin errors++; $display("FAIL mode_issue got a=%h issue=%b want 001 1", a_bcd, issue); end
    @(negedge clk);
  endtask

  task automatic test_hold_issue;
    press(K_CLR);
    press(4'd1); press(4'd2); press(4'd3); press(K_PLUS); press(4'd4); press(K_EQ);
    key_valid = 1'b1; key_code = 4'd1;
    @(negedge clk);
    checks++; if (a_bcd !== 12'h123 || issue !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL hold_in_issue got a=%h issue=%b rdy=%b want 123 0 1", a_bcd, issue, key_ready); end
    @(negedge clk); key_valid = 1'b0;
    checks++; if (a_bcd !== 12'h001 || b_bcd !== 12'h000 || entry_b !== 1'b0) begin errors++; $display("FAIL hold_accept got a=%h b=%h eb=%b want 001 000 0", a_bcd, b_bcd, entry_b); end
  endtask

  task automatic test_done;
    press(K_CLR);
    press(4'd1); press(4'd2); press(4'd3); press(K_PLUS); press(4'd4); press(4'd5); press(K_EQ);
    @(negedge clk);
    press(K_NEG); press(K_BKSP); press(K_CLR + 4'd0 - 4'd0 == K_CLR ? K_PLUS - 4'd0 - 4'd0 + 4'd2 : K_EQ);
    checks++; if (a_bcd !== 12'h123 || b_bcd !== 12'h045 || a_sign !== 1'b0 || entry_b !== 1'b1) begin errors++; $display("FAIL done_hold got a=%h b=%h s=%b eb=%b want 123 045 0 1", a_bcd, b_bcd, a_sign, entry_b); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL done_reissue got %b want 1", issue); end
    @(negedge clk);
`ifdef CHAIN_RESULT_EN
    res_bcd = 12'h168; res_sign = 1'b1; res_cout = 1'b1;
    press(K_MINUS);
    checks++; if (a_bcd !== 12'h123 || mode !== 1'b0 || entry_b !== 1'b1) begin errors++; $display("FAIL chain_cout got a=%h m=%b want 123 0", a_bcd, mode); end
    press(4'd3);
    checks++; if (a_bcd !== 12'h003 || entry_b !== 1'b0) begin errors++; $display("FAIL chain_cout_state got a=%h eb=%b want 003 0", a_bcd, entry_b); end
    press(K_PLUS); press(K_EQ); @(negedge clk);
    res_cout = 1'b0;
    press(K_MINUS);
    checks++; if (a_bcd !== 12'h168 || a_sign !== 1'b1 || mode !== 1'b1 || b_bcd !== 12'h000) begin errors++; $display("FAIL chain_load got a=%h s=%b m=%b b=%h want 168 1 1 000", a_bcd, a_sign, mode, b_bcd); end
    press(4'd7);
    checks++; if (a_bcd !== 12'h168 || b_bcd !== 12'h007 || entry_b !== 1'b1) begin errors++; $display("FAIL chain_enter_b got a=%h b=%h want 168 007", a_bcd, b_bcd); end
`else
    res_bcd = 12'h168; res_sign = 1'b1; res_cout = 1'b0;
    press(K_MINUS);
    checks++; if (a_bcd !== 12'h123 || a_sign !== 1'b0 || mode !== 1'b0 || entry_b !== 1'b1) begin errors++; $display("FAIL done_op_ignored got a=%h s=%b m=%b want 123 0 0", a_bcd, a_sign, mode); end
    press(4'd7);
    checks++; if (a_bcd !== 12'h007 || b_bcd !== 12'h000 || entry_b !== 1'b0) begin errors++; $display("FAIL done_digit got a=%h b=%h eb=%b want 007 000 0", a_bcd, b_bcd, entry_b); end
`endif
  endtask

  task automatic test_rst_mid;
    press(K_CLR);
    press(4'd4); press(4'd2); press(K_MINUS); press(4'd3); press(K_NEG);
    checks++; if (a_bcd !== 12'h042 || entry_b !== 1'b1 || b_sign !== 1'b1) begin errors++; $display("FAIL rst_setup got a=%h eb=%b bs=%b want 042 1 1", a_bcd, entry_b, b_sign); end
    rst = 1'b1; key_valid = 1'b1; key_code = 4'd5;
    #1;
    checks++; if (a_bcd !== 12'h000 || b_bcd !== 12'h000) begin errors++; $display("FAIL rst_ops got a=%h b=%h want 000 000", a_bcd, b_bcd); end
    checks++; if ({a_sign, b_sign, mode, issue, entry_b, key_ready} !== 6'b000001) begin errors++; $display("FAIL rst_ctrl got %b want 000001", {a_sign, b_sign, mode, issue, entry_b, key_ready}); end
    @(negedge clk);
    checks++; if (a_bcd !== 12'h000) begin errors++; $display("FAIL rst_key_override got %h want 000", a_bcd); end
    rst = 1'b0; key_valid = 1'b0;
    press(4'd8);
    checks++; if (a_bcd !== 12'h008 || entry_b !== 1'b0) begin errors++; $display("FAIL rst_enter_a got a=%h eb=%b want 008 0", a_bcd, entry_b); end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    res_bcd = 12'h000; res_sign = 1'b0; res_cout = 1'b0;
    test_reset;
    test_basic;
    test_digit_limit;
    test_signs;
    test_mode_overwrite;
    test_hold_issue;
    test_done;
    test_rst_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
